// File: rtl/difftest_commit_stage.sv
// difftest_commit_stage
//   Commit tap for simulation and difftest. Retire channels from cpu_top are
//   delayed DELAY register stages before they feed the DifftestInstrCommit
//   instances. The block also keeps cycle and instruction counters, detects
//   the trap instruction and a no-commit watchdog timeout, and drives the
//   DifftestTrapEvent fields.
// Ports
//   clock, reset_n                       clock, async active-low reset
//   commit_{valid,pc,instr,wen,waddr,wdata}_i
//                                        per-channel retire info; channel 0 is oldest
//   trap_reg_i                           $a0, sampled when the trap is detected
//   dly_{valid,pc,instr,wen,waddr,wdata}_o
//                                        commit info after DELAY cycles
//   cycle_cnt_o, instr_cnt_o             64-bit cycle / retired-instruction counters
//   trap_valid_o, trap_code_o, trap_pc_o trap / timeout report
module difftest_commit_stage #(
    parameter int          COMMIT_WIDTH = 2,
    parameter int          DELAY        = 1,
    parameter logic [31:0] TRAP_INSTR   = 32'h8000_0000,
    parameter int          TIMEOUT_CYC  = 10000
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [COMMIT_WIDTH-1:0]    commit_valid_i,
    input  logic [COMMIT_WIDTH*32-1:0] commit_pc_i,
    input  logic [COMMIT_WIDTH*32-1:0] commit_instr_i,
    input  logic [COMMIT_WIDTH-1:0]    commit_wen_i,
    input  logic [COMMIT_WIDTH*5-1:0]  commit_waddr_i,
    input  logic [COMMIT_WIDTH*32-1:0] commit_wdata_i,
    input  logic [31:0]                trap_reg_i,
    output logic [COMMIT_WIDTH-1:0]    dly_valid_o,
    output logic [COMMIT_WIDTH*32-1:0] dly_pc_o,
    output logic [COMMIT_WIDTH*32-1:0] dly_instr_o,
    output logic [COMMIT_WIDTH-1:0]    dly_wen_o,
    output logic [COMMIT_WIDTH*5-1:0]  dly_waddr_o,
    output logic [COMMIT_WIDTH*32-1:0] dly_wdata_o,
    output logic [63:0]                cycle_cnt_o,
    output logic [63:0]                instr_cnt_o,
    output logic                       trap_valid_o,
    output logic [2:0]                 trap_code_o,
    output logic [31:0]                trap_pc_o
);
    localparam int CW = COMMIT_WIDTH;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_TRAPPED = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    // Idle count at which a further empty cycle means timeout.
    localparam logic [31:0] IDLE_LIM = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

    logic [1:0]  state_q, state_d;
    logic [63:0] cycle_cnt_q, cycle_cnt_d;
    logic [63:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] idle_q, idle_d;
    logic        trap_valid_q, trap_valid_d;
    logic [2:0]  trap_code_q, trap_code_d;
    logic [31:0] trap_pc_q, trap_pc_d;

    logic [CW-1:0]    vld_pipe_q   [DELAY];
    logic [CW-1:0]    vld_pipe_d   [DELAY];
    logic [CW*32-1:0] pc_pipe_q    [DELAY];
    logic [CW*32-1:0] pc_pipe_d    [DELAY];
    logic [CW*32-1:0] instr_pipe_q [DELAY];
    logic [CW*32-1:0] instr_pipe_d [DELAY];
    logic [CW-1:0]    wen_pipe_q   [DELAY];
    logic [CW-1:0]    wen_pipe_d   [DELAY];
    logic [CW*5-1:0]  waddr_pipe_q [DELAY];
    logic [CW*5-1:0]  waddr_pipe_d [DELAY];
    logic [CW*32-1:0] wdata_pipe_q [DELAY];
    logic [CW*32-1:0] wdata_pipe_d [DELAY];

    logic          trap_hit;
    logic [31:0]   trap_lane_pc;
    logic [CW-1:0] lane_mask;
    logic [CW-1:0] ev;
    logic [63:0]   n_commit;
    logic          idle_expire;

    // First trap lane wins; every younger lane in the same cycle is dropped.
    always_comb begin
        trap_hit     = 1'b0;
        trap_lane_pc = 32'd0;
        lane_mask    = '1;
        for (int k = 0; k < CW; k++) begin
            if (trap_hit) begin
                lane_mask[k] = 1'b0;
            end else if (commit_valid_i[k] && commit_instr_i[32*k +: 32] == TRAP_INSTR) begin
                trap_hit     = 1'b1;
                trap_lane_pc = commit_pc_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        ev = (state_q == ST_RUN) ? (commit_valid_i & lane_mask) : '0;
        n_commit = 64'd0;
        for (int k = 0; k < CW; k++) n_commit = n_commit + 64'(ev[k]);
        idle_expire = (TIMEOUT_CYC != 0) && (ev == '0) && (idle_q == IDLE_LIM);
    end

    always_comb begin
        state_d      = state_q;
        cycle_cnt_d  = cycle_cnt_q;
        instr_cnt_d  = instr_cnt_q;
        idle_d       = idle_q;
        trap_valid_d = trap_valid_q;
        trap_code_d  = trap_code_q;
        trap_pc_d    = trap_pc_q;
        if (state_q == ST_RUN) begin
            cycle_cnt_d = cycle_cnt_q + 64'd1;
            instr_cnt_d = instr_cnt_q + n_commit;
            idle_d      = (ev != '0) ? 32'd0 : idle_q + 32'd1;
            // A trap implies a commit, so it can never coincide with expiry.
            if (trap_hit) begin
                state_d      = ST_TRAPPED;
                trap_valid_d = 1'b1;
                trap_code_d  = (trap_reg_i == 32'd0) ? 3'd0 : 3'd1;
                trap_pc_d    = trap_lane_pc;
            end else if (idle_expire) begin
                state_d      = ST_TIMEOUT;
                trap_valid_d = 1'b1;
                trap_code_d  = 3'd4;
                trap_pc_d    = 32'd0;
            end
        end
    end

    // Pipe shifts in every state so commits already in flight still drain.
    always_comb begin
        vld_pipe_d[0]   = ev;
        pc_pipe_d[0]    = commit_pc_i;
        instr_pipe_d[0] = commit_instr_i;
        wen_pipe_d[0]   = commit_wen_i & ev;
        waddr_pipe_d[0] = commit_waddr_i;
        wdata_pipe_d[0] = commit_wdata_i;
        for (int s = 1; s < DELAY; s++) begin
            vld_pipe_d[s]   = vld_pipe_q[s-1];
            pc_pipe_d[s]    = pc_pipe_q[s-1];
            instr_pipe_d[s] = instr_pipe_q[s-1];
            wen_pipe_d[s]   = wen_pipe_q[s-1];
            waddr_pipe_d[s] = waddr_pipe_q[s-1];
            wdata_pipe_d[s] = wdata_pipe_q[s-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            cycle_cnt_q  <= 64'd0;
            instr_cnt_q  <= 64'd0;
            idle_q       <= 32'd0;
            trap_valid_q <= 1'b0;
            trap_code_q  <= 3'd0;
            trap_pc_q    <= 32'd0;
            for (int s = 0; s < DELAY; s++) begin
                vld_pipe_q[s]   <= '0;
                pc_pipe_q[s]    <= '0;
                instr_pipe_q[s] <= '0;
                wen_pipe_q[s]   <= '0;
                waddr_pipe_q[s] <= '0;
                wdata_pipe_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cycle_cnt_q  <= cycle_cnt_d;
            instr_cnt_q  <= instr_cnt_d;
            idle_q       <= idle_d;
            trap_valid_q <= trap_valid_d;
            trap_code_q  <= trap_code_d;
            trap_pc_q    <= trap_pc_d;
            for (int s = 0; s < DELAY; s++) begin
                vld_pipe_q[s]   <= vld_pipe_d[s];
                pc_pipe_q[s]    <= pc_pipe_d[s];
                instr_pipe_q[s] <= instr_pipe_d[s];
                wen_pipe_q[s]   <= wen_pipe_d[s];
                waddr_pipe_q[s] <= waddr_pipe_d[s];
                wdata_pipe_q[s] <= wdata_pipe_d[s];
            end
        end
    end

    assign dly_valid_o  = vld_pipe_q[DELAY-1];
    assign dly_pc_o     = pc_pipe_q[DELAY-1];
    assign dly_instr_o  = instr_pipe_q[DELAY-1];
    assign dly_wen_o    = wen_pipe_q[DELAY-1];
    assign dly_waddr_o  = waddr_pipe_q[DELAY-1];
    assign dly_wdata_o  = wdata_pipe_q[DELAY-1];
    assign cycle_cnt_o  = cycle_cnt_q;
    assign instr_cnt_o  = instr_cnt_q;
    assign trap_valid_o = trap_valid_q;
    assign trap_code_o  = trap_code_q;
    assign trap_pc_o    = trap_pc_q;

endmodule

// File: tb/tb_difftest_commit_stage.sv
// Bench for difftest_commit_stage: two instances share the same stimulus,
// one with DELAY=3 / TIMEOUT_CYC=8 and one with DELAY=1 / TIMEOUT_CYC=0.
// A per-instance reference model tracks the run/trap/timeout outcome,
// counters and a history of accepted commits.
module tb_difftest_commit_stage;
    localparam logic [31:0] TRAP = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  cv;
    logic [63:0] cp, ci, cwd;
    logic [1:0]  cw;
    logic [9:0]  cwa;
    logic [31:0] treg;

    logic [1:0]  o_valid [2];
    logic [63:0] o_pc    [2];
    logic [63:0] o_instr [2];
    logic [1:0]  o_wen   [2];
    logic [9:0]  o_waddr [2];
    logic [63:0] o_wdata [2];
    logic [63:0] o_cyc   [2];
    logic [63:0] o_icnt  [2];
    logic        o_tv    [2];
    logic [2:0]  o_code  [2];
    logic [31:0] o_tpc   [2];

    always #5 clock = ~clock;

    difftest_commit_stage #(.COMMIT_WIDTH(2), .DELAY(3), .TRAP_INSTR(TRAP), .TIMEOUT_CYC(8)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .commit_valid_i(cv), .commit_pc_i(cp), .commit_instr_i(ci),
        .commit_wen_i(cw), .commit_waddr_i(cwa), .commit_wdata_i(cwd), .trap_reg_i(treg),
        .dly_valid_o(o_valid[0]), .dly_pc_o(o_pc[0]), .dly_instr_o(o_instr[0]),
        .dly_wen_o(o_wen[0]), .dly_waddr_o(o_waddr[0]), .dly_wdata_o(o_wdata[0]),
        .cycle_cnt_o(o_cyc[0]), .instr_cnt_o(o_icnt[0]),
        .trap_valid_o(o_tv[0]), .trap_code_o(o_code[0]), .trap_pc_o(o_tpc[0]));

    difftest_commit_stage #(.COMMIT_WIDTH(2), .DELAY(1), .TRAP_INSTR(TRAP), .TIMEOUT_CYC(0)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .commit_valid_i(cv), .commit_pc_i(cp), .commit_instr_i(ci),
        .commit_wen_i(cw), .commit_waddr_i(cwa), .commit_wdata_i(cwd), .trap_reg_i(treg),
        .dly_valid_o(o_valid[1]), .dly_pc_o(o_pc[1]), .dly_instr_o(o_instr[1]),
        .dly_wen_o(o_wen[1]), .dly_waddr_o(o_waddr[1]), .dly_wdata_o(o_wdata[1]),
        .cycle_cnt_o(o_cyc[1]), .instr_cnt_o(o_icnt[1]),
        .trap_valid_o(o_tv[1]), .trap_code_o(o_code[1]), .trap_pc_o(o_tpc[1]));

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0]  v;
        logic [1:0]  wen;
        logic [63:0] pc;
        logic [63:0] instr;
        logic [9:0]  waddr;
        logic [63:0] wdata;
    } rec_t;

    int          dly_of [2] = '{3, 1};
    int          tmo_of [2] = '{8, 0};
    rec_t        hist   [2][4];   // hist[i][0] = commit record accepted at the last edge
    int          m_st   [2];      // 0 run, 1 trapped, 2 timed out
    logic [63:0] m_cyc  [2];
    logic [63:0] m_icnt [2];
    int          m_idle [2];
    logic [2:0]  m_code [2];
    logic [31:0] m_tpc  [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 4; s++) hist[i][s] = '0;
            m_st[i] = 0; m_cyc[i] = 0; m_icnt[i] = 0; m_idle[i] = 0;
            m_code[i] = 0; m_tpc[i] = 0;
        end
    endtask

    // Applies one clock edge worth of behaviour using the inputs held across it.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            rec_t r;
            r = '0;
            if (m_st[i] == 0) begin
                int t;
                int cnt;
                t = 2;
                cnt = 0;
                for (int k = 0; k < 2; k++)
                    if (t == 2 && cv[k] && ci[32*k +: 32] == TRAP) t = k;
                for (int k = 0; k < 2; k++)
                    if (cv[k] && k <= t) begin r.v[k] = 1'b1; cnt++; end
                m_cyc[i]  = m_cyc[i] + 1;
                m_icnt[i] = m_icnt[i] + 64'(cnt);
                if (t < 2) begin
                    m_st[i] = 1; m_code[i] = (treg == 0) ? 3'd0 : 3'd1; m_tpc[i] = cp[32*t +: 32];
                end else if (cnt == 0) begin
                    m_idle[i]++;
                    if (tmo_of[i] != 0 && m_idle[i] == tmo_of[i]) begin
                        m_st[i] = 2; m_code[i] = 3'd4; m_tpc[i] = 0;
                    end
                end else begin
                    m_idle[i] = 0;
                end
            end
            r.wen = cw & r.v; r.pc = cp; r.instr = ci; r.waddr = cwa; r.wdata = cwd;
            for (int s = 3; s > 0; s--) hist[i][s] = hist[i][s-1];
            hist[i][0] = r;
        end
    endtask

    task automatic chk_all();
        for (int i = 0; i < 2; i++) begin
            rec_t e;
            e = hist[i][dly_of[i]-1];
            chk($sformatf("u%0d_vld", i), 64'(o_valid[i]), 64'(e.v));
            chk($sformatf("u%0d_wen", i), 64'(o_wen[i]), 64'(e.wen));
            for (int k = 0; k < 2; k++) if (e.v[k]) begin
                chk($sformatf("u%0d_pc%0d", i, k),    64'(o_pc[i][32*k +: 32]),    64'(e.pc[32*k +: 32]));
                chk($sformatf("u%0d_instr%0d", i, k), 64'(o_instr[i][32*k +: 32]), 64'(e.instr[32*k +: 32]));
                chk($sformatf("u%0d_waddr%0d", i, k), 64'(o_waddr[i][5*k +: 5]),   64'(e.waddr[5*k +: 5]));
                chk($sformatf("u%0d_wdata%0d", i, k), 64'(o_wdata[i][32*k +: 32]), 64'(e.wdata[32*k +: 32]));
            end
            chk($sformatf("u%0d_cyc", i),  o_cyc[i],  m_cyc[i]);
            chk($sformatf("u%0d_icnt", i), o_icnt[i], m_icnt[i]);
            chk($sformatf("u%0d_tv", i),   64'(o_tv[i]),   64'(m_st[i] != 0));
            chk($sformatf("u%0d_code", i), 64'(o_code[i]), 64'(m_code[i]));
            chk($sformatf("u%0d_tpc", i),  64'(o_tpc[i]),  64'(m_tpc[i]));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_step();
        chk_all();
    endtask

    // Asserts reset between edges: outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        @(posedge clock);
        #1;
        chk_all();
        reset_n = 1'b1;
    endtask

    task automatic drive(input int mode);
        cp  = {$urandom() & 32'hffff_fffc, $urandom() & 32'hffff_fffc};
        cw  = 2'($urandom());
        cwa = 10'($urandom());
        cwd = {$urandom(), $urandom()};
        case ($urandom_range(0, 2))
            0: treg = 32'd0;
            1: treg = 32'd5;
            default: treg = $urandom();
        endcase
        cv = 2'b00;
        for (int k = 0; k < 2; k++) begin
            case (mode)
                0: cv[k] = ($urandom_range(0, 3) != 0);
                1: cv[k] = ($urandom_range(0, 9) == 0);
                default: cv[k] = 1'b0;
            endcase
            ci[32*k +: 32] = ($urandom_range(0, (mode == 0) ? 40 : 8) == 0) ? TRAP : $urandom();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        cv = 0; cp = 0; ci = 0; cw = 0; cwa = 0; cwd = 0; treg = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk_all();
        reset_n = 1'b1;

        // Two ordinary commits flow through unchanged.
        cv = 2'b11; cp = {32'h1c00_0004, 32'h1c00_0000}; ci = {32'h0000_0013, 32'h0000_0013};
        cw = 2'b01; cwa = {5'd2, 5'd1}; cwd = {32'h2222, 32'h1111};
        tick();
        chk("t1_pc1", 64'(o_pc[1][63:32]), 64'h1c00_0004);
        chk("t1_icnt", o_icnt[1], 64'd2);

        // Trap in lane 0 with lane 1 valid and nonzero $a0.
        cv = 2'b11; ci = {32'h0000_0013, TRAP}; treg = 32'd5;
        tick();
        chk("t4_code", 64'(o_code[1]), 64'd1);
        chk("t4_vld", 64'(o_valid[1]), 64'b01);
        chk("t4_icnt", o_icnt[1], 64'd3);
        cv = 2'b11; ci = 64'h0000_0013_0000_0013;
        repeat (4) tick();

        for (int ep = 0; ep < 24; ep++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                drive(ep % 3);
                tick();
                if (ep % 4 == 1 && c == 30) do_reset();
            end
        end

        // Long quiet stretch: disabled watchdog stays silent.
        do_reset();
        cv = 2'b00;
        repeat (1000) tick();
        chk("t5_b_tv", 64'(o_tv[1]), 64'd0);
        chk("t5_a_code", 64'(o_code[0]), 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
